// File: rtl/seq_comparator.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle, with early exit.
// Define SEQ_COMPARATOR_MINMAX_EN to add registered min/max outputs.
module seq_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
`ifdef SEQ_COMPARATOR_MINMAX_EN
  output logic             gt,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] max
`else
  output logic             gt
`endif
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned IDXW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NSLOT = 1 << IDXW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("seq_comparator: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  logic [1:0]       state, state_n;
  logic [IDXW-1:0]  idx, idx_n;
  logic [WIDTH-1:0] op_a, op_a_n;
  logic [WIDTH-1:0] op_b, op_b_n;
  logic             sign_q, sign_n;
  logic             busy_n, done_n, eq_n, lt_n, gt_n;
`ifdef SEQ_COMPARATOR_MINMAX_EN
  logic [WIDTH-1:0] min_n, max_n;
`endif

  // Chunk views of the latched operands, padded to a power-of-two table so idx indexes it exactly.
  logic [CHUNK-1:0] a_slot [NSLOT];
  logic [CHUNK-1:0] b_slot [NSLOT];

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < N) begin : g_real
      assign a_slot[g] = op_a[g*CHUNK +: CHUNK];
      assign b_slot[g] = op_b[g*CHUNK +: CHUNK];
    end else begin : g_pad
      assign a_slot[g] = '0;
      assign b_slot[g] = '0;
    end
  end

  logic [CHUNK-1:0] a_cur, b_cur, a_cmp, b_cmp;
  logic             msb_flip;

  // Flipping the sign bit of the top chunk turns an unsigned compare into a two's-complement one.
  always_comb begin
    a_cur    = a_slot[idx];
    b_cur    = b_slot[idx];
    msb_flip = sign_q && (idx == IDXW'(N - 1));
    a_cmp    = a_cur;
    b_cmp    = b_cur;
    a_cmp[CHUNK-1] = a_cur[CHUNK-1] ^ msb_flip;
    b_cmp[CHUNK-1] = b_cur[CHUNK-1] ^ msb_flip;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    op_a_n  = op_a;
    op_b_n  = op_b;
    sign_n  = sign_q;
    busy_n  = busy;
    done_n  = 1'b0;
    eq_n    = eq;
    lt_n    = lt;
    gt_n    = gt;
`ifdef SEQ_COMPARATOR_MINMAX_EN
    min_n   = min;
    max_n   = max;
`endif
    case (state)
      IDLE, DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
        if (start) begin
          op_a_n  = A;
          op_b_n  = B;
          sign_n  = sign;
          idx_n   = IDXW'(N - 1);
          busy_n  = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (a_cmp != b_cmp) begin
          eq_n    = 1'b0;
          lt_n    = (a_cmp < b_cmp);
          gt_n    = (a_cmp > b_cmp);
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else if (idx == '0) begin
          eq_n    = 1'b1;
          lt_n    = 1'b0;
          gt_n    = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          idx_n = idx - IDXW'(1);
        end
`ifdef SEQ_COMPARATOR_MINMAX_EN
        if (done_n) begin
          min_n = lt_n ? op_a : op_b;
          max_n = lt_n ? op_b : op_a;
        end
`endif
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      sign_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      eq     <= 1'b0;
      lt     <= 1'b0;
      gt     <= 1'b0;
`ifdef SEQ_COMPARATOR_MINMAX_EN
      min    <= '0;
      max    <= '0;
`endif
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      op_a   <= op_a_n;
      op_b   <= op_b_n;
      sign_q <= sign_n;
      busy   <= busy_n;
      done   <= done_n;
      eq     <= eq_n;
      lt     <= lt_n;
      gt     <= gt_n;
`ifdef SEQ_COMPARATOR_MINMAX_EN
      min    <= min_n;
      max    <= max_n;
`endif
    end
  end

endmodule

// File: tb/tb_seq_comparator.sv
// Randomised self-checking bench for seq_comparator (WIDTH=16, CHUNK=4).
module tb_seq_comparator;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;
  localparam int unsigned N     = WIDTH / CHUNK;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic             sign;
  logic             busy, done, eq, lt, gt;
`ifdef SEQ_COMPARATOR_MINMAX_EN
  logic [WIDTH-1:0] min_o, max_o;
`endif

  int vectors;
  int miscompares;

  seq_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a_op), .B(b_op), .sign(sign),
    .busy(busy), .done(done), .eq(eq), .lt(lt),
`ifdef SEQ_COMPARATOR_MINMAX_EN
    .gt(gt), .min(min_o), .max(max_o)
`else
    .gt(gt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {eq, lt, gt} from a whole-word compare.
  function automatic logic [2:0] ref_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic s);
    logic l, g;
    if (s) begin
      l = $signed(a) < $signed(b);
      g = $signed(a) > $signed(b);
    end else begin
      l = a < b;
      g = a > b;
    end
    return {a == b, l, g};
  endfunction

  // Reference: number of compare edges = position of the first differing chunk from the MSB end.
  function automatic int ref_edges(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    x = a ^ b;
    for (int p = WIDTH - 1; p >= 0; p--)
      if (x[p]) return N - (p / CHUNK);
    return N;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and count edges after acceptance until done appears (bounded).
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                       output int edges, output bit busy_ok);
    a_op = a; b_op = b; sign = s; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    busy_ok = 1'b1;
    while (!done && edges < int'(N) + 2) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      edges++;
    end
    if (busy) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_op = '0; b_op = '0; sign = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({busy, done, eq, lt, gt} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 00000", {busy, done, eq, lt, gt});
    end
`ifdef SEQ_COMPARATOR_MINMAX_EN
    vectors++;
    if ({min_o, max_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_minmax: got min=%h max=%h want 0/0", min_o, max_o);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_equal();
    int e; bit bok;
    do_op(16'h1234, 16'h1234, 1'b0, e, bok);
    vectors++;
    if ({eq, lt, gt} !== 3'b100 || e !== 4 || !bok) begin
      miscompares++;
      $display("FAIL equal: flags=%b edges=%0d busy_ok=%0d want 100/4/1", {eq, lt, gt}, e, bok);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || {eq, lt, gt} !== 3'b100) begin
      miscompares++;
      $display("FAIL equal_done_pulse: done=%b flags=%b want 0/100", done, {eq, lt, gt});
    end
  endtask

  task automatic test_sign_msb();
    int e; bit bok;
    do_op(16'h8000, 16'h7FFF, 1'b0, e, bok);
    vectors++;
    if ({eq, lt, gt} !== 3'b001 || e !== 1 || !bok) begin
      miscompares++;
      $display("FAIL sign_msb_unsigned: flags=%b edges=%0d want 001/1", {eq, lt, gt}, e);
    end
    do_op(16'h8000, 16'h7FFF, 1'b1, e, bok);
    vectors++;
    if ({eq, lt, gt} !== 3'b010 || e !== 1 || !bok) begin
      miscompares++;
      $display("FAIL sign_msb_signed: flags=%b edges=%0d want 010/1", {eq, lt, gt}, e);
    end
  endtask

  task automatic test_last_chunk();
    int e; bit bok;
    do_op(16'h0012, 16'h0013, 1'b1, e, bok);
    vectors++;
    if ({eq, lt, gt} !== 3'b010 || e !== 4 || !bok) begin
      miscompares++;
      $display("FAIL last_chunk: flags=%b edges=%0d want 010/4", {eq, lt, gt}, e);
    end
  endtask

  task automatic test_start_handling();
    int e; bit bok;
    do_op(16'h5000, 16'h4000, 1'b0, e, bok);   // leaves gt set
    a_op = 16'h1234; b_op = 16'h1235; sign = 1'b0; start = 1'b1;
    tick();
    a_op = 16'hFFFF; b_op = 16'h0000;
    vectors++;
    if ({busy, eq, lt, gt} !== 4'b1001) begin
      miscompares++;
      $display("FAIL flags_hold_on_start: busy+flags=%b want 1001", {busy, eq, lt, gt});
    end
    tick(); tick();
    start = 1'b0;
    e = 2;
    while (!done && e < int'(N) + 2) begin tick(); e++; end
    vectors++;
    if ({eq, lt, gt} !== 3'b010 || e !== 4) begin
      miscompares++;
      $display("FAIL start_while_busy: flags=%b edges=%0d want 010/4", {eq, lt, gt}, e);
    end
    // start during the done cycle
    a_op = 16'h9000; b_op = 16'h1000; sign = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_done: busy=%b done=%b want 1/0", busy, done);
    end
    e = 0;
    while (!done && e < int'(N) + 2) begin tick(); e++; end
    vectors++;
    if ({eq, lt, gt} !== 3'b010 || e !== 1) begin
      miscompares++;
      $display("FAIL start_in_done_result: flags=%b edges=%0d want 010/1", {eq, lt, gt}, e);
    end
  endtask

  task automatic test_reset_mid();
    int e, pulses; bit bok;
    do_op(16'h5000, 16'h4000, 1'b0, e, bok);
    a_op = 16'h1234; b_op = 16'h1235; sign = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy, done, eq, lt, gt} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_mid_op: got %b want 00000", {busy, done, eq, lt, gt});
    end
    pulses = 0;
    repeat (6) begin tick(); if (done) pulses++; end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL reset_no_done: got %0d done pulses want 0", pulses);
    end
    do_op(16'h0001, 16'h0000, 1'b0, e, bok);
    vectors++;
    if ({eq, lt, gt} !== 3'b001 || e !== 4 || !bok) begin
      miscompares++;
      $display("FAIL after_reset_op: flags=%b edges=%0d want 001/4", {eq, lt, gt}, e);
    end
  endtask

`ifdef SEQ_COMPARATOR_MINMAX_EN
  task automatic test_minmax();
    int e; bit bok;
    do_op(16'hFFFF, 16'h0001, 1'b1, e, bok);
    vectors++;
    if ({eq, lt, gt} !== 3'b010 || min_o !== 16'hFFFF || max_o !== 16'h0001) begin
      miscompares++;
      $display("FAIL minmax_signed: flags=%b min=%h max=%h want 010/ffff/0001", {eq, lt, gt}, min_o, max_o);
    end
    do_op(16'hFFFF, 16'h0001, 1'b0, e, bok);
    vectors++;
    if ({eq, lt, gt} !== 3'b001 || min_o !== 16'h0001 || max_o !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL minmax_unsigned: flags=%b min=%h max=%h want 001/0001/ffff", {eq, lt, gt}, min_o, max_o);
    end
  endtask
`endif

  task automatic test_random();
    logic [WIDTH-1:0] a, b, r;
    logic s;
    logic [2:0] ef;
    int e, ee, gap; bit bok;
    for (int i = 0; i < 300; i++) begin
      a = WIDTH'($urandom);
      r = WIDTH'($urandom);
      case ($urandom_range(0, 4))
        0:       b = a;
        1:       b = {a[15:4], r[3:0]};
        2:       b = {a[15:8], r[7:0]};
        3:       b = {a[15:12], r[11:0]};
        default: b = r;
      endcase
      s = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      do_op(a, b, s, e, bok);
      ef = ref_flags(a, b, s);
      ee = ref_edges(a, b);
      vectors++;
      if ({eq, lt, gt} !== ef || e !== ee || !bok) begin
        miscompares++;
        $display("FAIL random[%0d] a=%h b=%h s=%0d: flags=%b edges=%0d busy_ok=%0d want %b/%0d/1",
                 i, a, b, s, {eq, lt, gt}, e, bok, ef, ee);
      end
`ifdef SEQ_COMPARATOR_MINMAX_EN
      vectors++;
      if (min_o !== (ef[1] ? a : b) || max_o !== (ef[1] ? b : a)) begin
        miscompares++;
        $display("FAIL random_minmax[%0d]: min=%h max=%h want %h/%h",
                 i, min_o, max_o, ef[1] ? a : b, ef[1] ? b : a);
      end
`endif
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_equal();
    test_sign_msb();
    test_last_chunk();
    test_start_handling();
    test_reset_mid();
`ifdef SEQ_COMPARATOR_MINMAX_EN
    test_minmax();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
